// File: rtl/execute_unit.sv
// Execute stage: ALU, writeback select and register, GPIO output register, and a
// sequential shift-add multiplier that stalls upstream and retires into HI/LO.
module execute_unit #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          alu_op,
    input  logic [4:0]          shamt_EX,
    input  logic [1:0]          regsel_EX,
    input  logic                enhilo_EX,
    input  logic                regwrite_EX,
    input  logic                rdrt_EX,
    input  logic                GPIO_OUT,
    input  logic                GPIO_IN,
    input  logic [DATA_W-1:0]   readdata1_EX,
    input  logic [DATA_W-1:0]   readdata2_EX,
    input  logic [4:0]          rt_EX,
    input  logic [4:0]          rd_EX,
    input  logic [DATA_W-1:0]   gpio_in,
    output logic                stall_EX,
    output logic [DATA_W-1:0]   writedata_WB,
    output logic [4:0]          regdest_WB,
    output logic                regwrite_WB,
    output logic [DATA_W-1:0]   gpio_out,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } mul_state_t;

    mul_state_t              state;
    logic [CNT_W-1:0]        cnt;
    logic [2*DATA_W-1:0]     mcand;
    logic [DATA_W-1:0]       mplier;
    logic [2*DATA_W-1:0]     prod;
    logic                    neg;

    logic [DATA_W-1:0]       alu_result;
    logic [DATA_W-1:0]       wb_data;
    logic [4:0]              dest;
    logic                    signed_op;
    logic [DATA_W-1:0]       a_mag;
    logic [DATA_W-1:0]       b_mag;
    logic [2*DATA_W-1:0]     prod_signed;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'b0000: alu_result = readdata1_EX & readdata2_EX;
            4'b0001: alu_result = readdata1_EX | readdata2_EX;
            4'b0010: alu_result = ~(readdata1_EX | readdata2_EX);
            4'b0011: alu_result = readdata1_EX ^ readdata2_EX;
            4'b0100: alu_result = readdata1_EX + readdata2_EX;
            4'b0101: alu_result = readdata1_EX - readdata2_EX;
            4'b1000: alu_result = readdata2_EX << shamt_EX;
            4'b1001: alu_result = readdata2_EX >> shamt_EX;
            4'b1010: alu_result = $signed(readdata2_EX) >>> shamt_EX;
            4'b1100: alu_result = {{(DATA_W-1){1'b0}}, $signed(readdata1_EX) < $signed(readdata2_EX)};
            4'b1101: alu_result = {{(DATA_W-1){1'b0}}, readdata1_EX < readdata2_EX};
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        wb_data = alu_result;
        if (GPIO_IN)
            wb_data = gpio_in;
        else if (regsel_EX == 2'b01)
            wb_data = hi;
        else if (regsel_EX == 2'b10)
            wb_data = lo;
    end

    assign dest = rdrt_EX ? rt_EX : rd_EX;

    // Multiplier works on magnitudes; the sign is reapplied once at retirement.
    assign signed_op   = (alu_op == 4'b0110);
    assign a_mag       = (signed_op && readdata1_EX[DATA_W-1]) ? -readdata1_EX : readdata1_EX;
    assign b_mag       = (signed_op && readdata2_EX[DATA_W-1]) ? -readdata2_EX : readdata2_EX;
    assign prod_signed = neg ? -prod : prod;

    assign stall_EX = !rst && ((state == IDLE && enhilo_EX) || state == MUL);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the multiplier datapath is reset along with the control state so a
            // reset mid-multiply leaves no stale partial product behind.
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enhilo_EX) begin
                        mcand  <= {{DATA_W{1'b0}}, a_mag};
                        mplier <= b_mag;
                        prod   <= '0;
                        neg    <= signed_op && (readdata1_EX[DATA_W-1] ^ readdata2_EX[DATA_W-1]);
                        cnt    <= '0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (mplier[0])
                        prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1))
                        state <= DONE;
                end
                DONE: begin
                    {hi, lo} <= prod_signed;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A multiply never writes the register file, including its retiring DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            writedata_WB <= '0;
            regdest_WB   <= '0;
            regwrite_WB  <= 1'b0;
            gpio_out     <= '0;
        end else if (stall_EX) begin
            writedata_WB <= '0;
            regwrite_WB  <= 1'b0;
        end else begin
            writedata_WB <= wb_data;
            regdest_WB   <= dest;
            regwrite_WB  <= regwrite_EX && !enhilo_EX;
            if (GPIO_OUT)
                gpio_out <= readdata2_EX;
        end
    end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width; MUL state length equals DATA_W cycles.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_op  in  4  operation code from the control unit.
- shamt_EX  in  5  shift amount.
- regsel_EX  in  2  writeback source: 00 ALU, 01 HI, 10 LO.
- enhilo_EX  in  1  start mult/multu.
- regwrite_EX  in  1  instruction writes a register.
- rdrt_EX  in  1  destination select: 1 = rt, 0 = rd.
- GPIO_OUT  in  1  gpio write strobe.
- GPIO_IN  in  1  gpio read strobe.
- readdata1_EX  in  DATA_W  rs operand.
- readdata2_EX  in  DATA_W  rt operand.
- rt_EX, rd_EX  in  5 each  register fields.
- gpio_in  in  DATA_W  external input.
- stall_EX  out  1  upstream holds its EX instruction.
- writedata_WB  out  DATA_W  registered writeback data.
- regdest_WB  out  5  registered destination.
- regwrite_WB  out  1  registered write enable.
- gpio_out  out  DATA_W  gpio output register.
- hi, lo  out  DATA_W each  HI/LO registers.

Function
REQ-003 SHALL decode alu_op as: 0000 AND, 0001 OR, 0010 NOR, 0011 XOR, 0100 ADD, 0101 SUB, 1000 SLL, 1001 SRL, 1010 SRA, 1100 SLT, 1101 SLTU, with A=readdata1_EX and B=readdata2_EX; any other code SHALL give 0.
REQ-004 SHALL perform ADD/SUB modulo 2^DATA_W with no overflow flag; SLT SHALL compare signed and SLTU unsigned, each giving 1 or 0.
REQ-005 SHALL compute shifts as B shifted by shamt_EX; SRA SHALL sign-fill.
REQ-006 SHALL select writeback data with priority GPIO_IN (gpio_in), then regsel 01 (hi), then regsel 10 (lo), else the ALU result.
REQ-007 SHALL set regdest = rdrt_EX ? rt_EX : rd_EX.
REQ-008 SHALL give one-cycle latency: writedata_WB, regdest_WB and regwrite_WB SHALL register at each rising edge while stall_EX=0.
REQ-009 SHALL register writedata_WB=0 and regwrite_WB=0 while stall_EX=1, i.e. insert a bubble.
REQ-010 SHALL load gpio_out<=readdata2_EX on an edge where GPIO_OUT=1 and stall_EX=0, and otherwise hold gpio_out.
REQ-011 SHALL implement the multiplier as an FSM with states IDLE, MUL and DONE.
REQ-012 In IDLE with enhilo_EX=1, the unit SHALL latch |A| and |B|, latch the sign (alu_op 0110 signed, 0111 unsigned magnitudes), clear the counter and go to MUL.
REQ-013 In MUL, the unit SHALL do one shift-add step per cycle, go to DONE after DATA_W steps, and ignore all inputs meanwhile.
REQ-014 In DONE, the unit SHALL negate the 2*DATA_W product if the signs differ, write {hi,lo} at that edge and go to IDLE.
REQ-015 SHALL drive stall_EX=1 combinationally when (IDLE and enhilo_EX) or in MUL, and 0 in DONE, so that stall_EX is high 1+DATA_W cycles and the mult retires in DONE.
REQ-016 In DONE, enhilo_EX still high SHALL NOT restart the multiplier.
REQ-017 hi/lo SHALL change only on a DONE edge or on reset; mfhi/mflo issued after retirement SHALL read the new values.
REQ-018 A mult SHALL NOT produce regwrite_WB=1.

Reset
REQ-019 On rst=1 at a rising edge, the unit SHALL set writedata_WB, regdest_WB, regwrite_WB, gpio_out, hi and lo to 0, the FSM to IDLE and the counter to 0.
REQ-020 While rst=1, stall_EX SHALL be 0.
REQ-021 A reset during MUL or DONE SHALL abort the multiply and leave hi and lo at 0.
REQ-022 rst SHALL take priority over all other inputs.

Verification
REQ-023 ADD: A=0x7FFFFFFF, B=1, rd=5, regwrite=1 -> next cycle writedata_WB=0x80000000, regdest_WB=5, regwrite_WB=1.
REQ-024 SRA/SLT/SLTU: B=0x80000000 with shamt 4 -> 0xF8000000; SLT with A=0xFFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0.
REQ-025 MULT: A=-3, B=5 -> stall_EX high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, and mflo next returns 0xFFFFFFF1.
REQ-026 MULTU: A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE, with regwrite_WB=0 throughout.
REQ-027 Reset at MUL cycle 10 -> FSM IDLE, stall_EX=0, hi=lo=0; a subsequent ADD completes in 1 cycle.
REQ-028 GPIO: GPIO_OUT with B=0xA5 -> gpio_out=0xA5; GPIO_IN with gpio_in=0x3C, rd=7 -> writedata_WB=0x3C, regdest_WB=7.
